// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and width for the SPI master
package spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} spi_state_e;

    localparam int SPI_WIDTH = 8;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period counter; one-cycle tick every CLK_DIV clks while enabled
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] hp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_cnt <= '0;
        end else if (!en || hp_cnt == LAST) begin
            hp_cnt <= '0;
        end else begin
            hp_cnt <= hp_cnt + CW'(1);
        end
    end

    assign tick = en && (hp_cnt == LAST);

endmodule

// File: rtl/modport_spi_master.sv
// rtl/modport_spi_master.sv - single-byte mode-0 MSB-first SPI master with start/busy/done handshake
module modport_spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WIDTH   = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             cs_n
);

    localparam logic [3:0] LAST_HP = 4'(2 * WIDTH - 1);

    spi_state_e       state, state_d;
    logic [WIDTH-1:0] tx_sh, tx_sh_d;
    logic [WIDTH-1:0] rx_sh, rx_sh_d;
    logic [WIDTH-1:0] rx_data_d;
    logic [3:0]       bit_cnt, bit_cnt_d;
    logic             cs_n_d, sclk_d, mosi_d, busy_d, done_d;
    logic             hp_en, hp_tick;

    assign hp_en = (state == SETUP) || (state == XFER);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (hp_en),
        .tick  (hp_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            bit_cnt <= '0;
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            tx_sh   <= tx_sh_d;
            rx_sh   <= rx_sh_d;
            rx_data <= rx_data_d;
            bit_cnt <= bit_cnt_d;
            cs_n    <= cs_n_d;
            sclk    <= sclk_d;
            mosi    <= mosi_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        tx_sh_d   = tx_sh;
        rx_sh_d   = rx_sh;
        rx_data_d = rx_data;
        bit_cnt_d = bit_cnt;
        cs_n_d    = cs_n;
        sclk_d    = sclk;
        mosi_d    = mosi;
        busy_d    = busy;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                // done is still high on the first IDLE cycle; a start then is dropped
                if (start && !done) begin
                    state_d   = SETUP;
                    tx_sh_d   = tx_data;
                    rx_sh_d   = '0;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                end
            end
            SETUP: begin
                if (hp_tick) begin
                    state_d = XFER;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = tx_sh[WIDTH-1];
                end
            end
            XFER: begin
                if (hp_tick) begin
                    bit_cnt_d = bit_cnt + 4'd1;
                    // even half-period count ends a low phase: rising sclk edge
                    if (!bit_cnt[0]) begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh[WIDTH-2:0], miso};
                    end else begin
                        sclk_d  = 1'b0;
                        tx_sh_d = {tx_sh[WIDTH-2:0], 1'b0};
                        mosi_d  = tx_sh[WIDTH-2];
                    end
                    if (bit_cnt == LAST_HP) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                cs_n_d    = 1'b1;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                mosi_d    = 1'b0;
                rx_data_d = rx_sh;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_modport_spi_master.sv
// tb/tb_modport_spi_master.sv - scoreboard bench for modport_spi_master
module tb_modport_spi_master;

    localparam int LATENCY = 17 * 4 + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       busy, done, sclk, mosi, miso, cs_n;

    modport_spi_master #(.CLK_DIV(4), .WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs_n    (cs_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: either loopback, or a shift-out of sl_byte MSB first, advancing after each falling sclk
    bit         loop_mode = 1'b1;
    logic [7:0] sl_byte = 8'h00;
    logic [3:0] sl_idx = 4'd0;
    logic       sl_sclk_prev = 1'b0;

    always @(posedge clk) begin
        if (cs_n) sl_idx <= 4'd0;
        else if (sl_sclk_prev && !sclk) sl_idx <= sl_idx + 4'd1;
        sl_sclk_prev <= sclk;
    end

    assign miso = loop_mode ? mosi : sl_byte[3'd7 - sl_idx[2:0]];

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         t0;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_rx = 8'h00;

    logic [7:0] mon_bits = 8'h00;
    int         mon_pulses = 0;
    bit         mon_unstable = 1'b0;
    logic       mon_sclk_prev = 1'b0;
    logic       mon_cs_prev = 1'b1;
    logic       mon_done_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_bits = 8'h00; mon_pulses = 0; mon_unstable = 1'b0;
            mon_sclk_prev = 1'b0; mon_cs_prev = 1'b1; mon_done_prev = 1'b0;
        end else begin
            if (!cs_n && mon_cs_prev) begin
                mon_bits = 8'h00; mon_pulses = 0; mon_unstable = 1'b0;
            end
            if (sclk && !mon_sclk_prev) begin
                mon_bits = {mon_bits[6:0], mosi};
                mon_pulses++;
            end else if (sclk && mon_sclk_prev && mosi != mon_bits[0]) begin
                mon_unstable = 1'b1;
            end
            if (mon_done_prev) check("done_one_cycle", done, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rx_data", rx_data, e.rx);
                    check("mosi_byte", mon_bits, e.tx);
                    check("sclk_pulses", mon_pulses, 8);
                    check("latency", cyc - e.t0, LATENCY);
                    check("mosi_stable_high", mon_unstable, 0);
                    check("cs_n_at_done", cs_n, 1);
                    check("busy_at_done", busy, 0);
                    last_rx = e.rx;
                end
            end
            mon_sclk_prev = sclk;
            mon_cs_prev   = cs_n;
            mon_done_prev = done;
        end
    end

    task automatic issue(input logic [7:0] tx, input bit lp, input logic [7:0] sbyte);
        exp_t e;
        @(posedge clk); #1;
        loop_mode = lp; sl_byte = sbyte; tx_data = tx; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tx_data = ~tx;
        e.tx = tx; e.rx = lp ? tx : sbyte; e.t0 = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done_seen", done, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !done && sb.size() == 0) break;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        exp_t e;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mosi", mosi, 0);
        check("rst_rx_data", rx_data, 8'h00);
        rst_n = 1'b1;

        issue(8'hA5, 1'b1, 8'h00);
        wait_idle();

        issue(8'h96, 1'b0, 8'h3C);
        wait_idle();

        issue(8'hC3, 1'b1, 8'h00);
        repeat (9) @(posedge clk);
        #1; start = 1'b1; tx_data = 8'hFF;
        @(posedge clk); #1; start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("rx_hold", rx_data, last_rx);

        issue(8'h6E, 1'b0, 8'hB1);
        repeat (30) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        check("abort_cs_n", cs_n, 1);
        check("abort_busy", busy, 0);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        sb.delete();
        last_rx = 8'h00;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_no_xfer_busy", busy, 0);
        check("abort_rx_data", rx_data, 8'h00);
        issue(8'h5A, 1'b1, 8'h00);
        wait_idle();

        issue(8'h01, 1'b0, 8'hE7);
        wait_done();
        @(posedge clk); #1; start = 1'b1; tx_data = 8'h80; loop_mode = 1'b1;
        @(posedge clk); #1; start = 1'b0; tx_data = 8'h00;
        e.tx = 8'h80; e.rx = 8'h80; e.t0 = cyc;
        sb.push_back(e);
        wait_idle();

        issue(8'h2D, 1'b0, 8'h4B);
        wait_done();
        start = 1'b1; tx_data = 8'h99;
        @(posedge clk); #1; start = 1'b0;
        repeat (20) @(negedge clk);
        check("start_in_done_ignored", busy, 0);

        for (int k = 0; k < 8; k++) begin
            r = 8'($urandom_range(0, 255));
            issue(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end

        repeat (5) @(negedge clk);
        check("final_rx_hold", rx_data, last_rx);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
